// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: opcodes, next-PC select codes,
// the NoOp instruction word and the fetch FSM state type.
package fetch_unit_pkg;

  localparam logic [5:0] OP_NOOP = 6'b111111;
  localparam logic [5:0] OP_J    = 6'b000001;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLT  = 6'b000110;
  localparam logic [5:0] OP_BLE  = 6'b000111;
  localparam logic [5:0] OP_LI   = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001001;
  localparam logic [5:0] OP_LWI  = 6'b001010;
  localparam logic [5:0] OP_SWI  = 6'b001011;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_REG = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;
  localparam logic [1:0] PC_SRC_HOLD    = 2'b11;

  localparam logic [31:0] IR_NOOP = {OP_NOOP, 26'd0};

  typedef logic [0:0] fetchState_t;
  localparam fetchState_t F_IDLE = 1'b0;
  localparam fetchState_t F_REQ  = 1'b1;

  // Watchdog fires on the 15th F_REQ cycle, i.e. when the count reads 14.
  localparam logic [3:0] WD_LIMIT = 4'd14;

endpackage

// File: rtl/fetch_unit_branch_cond.sv
// Combinational branch-taken decision from the branch type select and ALU flags.
module branch_cond (
  input  logic zeroCond,
  input  logic bltCond,
  input  logic aluZero,
  input  logic aluNeg,
  output logic taken
);

  always_comb begin
    taken = 1'b0;
    case ({zeroCond, bltCond})
      2'b00:   taken = ~aluZero;
      2'b10:   taken = aluZero;
      2'b01:   taken = aluNeg;
      default: taken = aluZero | aluNeg;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, next-PC selection, branch resolution
// and a request/acknowledge fetch FSM. FETCH_TIMEOUT_EN adds a fetch watchdog.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        ir_write,
  input  logic        pc_write_cond,
  input  logic        alu_zero_cond,
  input  logic        blt_cond,
  input  logic [1:0]  pc_source,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
`ifdef FETCH_TIMEOUT_EN
  output logic        fetch_err,
`endif
  output logic        fetch_busy
);

  fetchState_t state;
  logic [31:0] aluOutQ;
  logic [31:0] nextPc;
  logic        branchTaken;
  logic        pcUpdate;

  branch_cond uBranchCond (
    .zeroCond (alu_zero_cond),
    .bltCond  (blt_cond),
    .aluZero  (alu_zero),
    .aluNeg   (alu_neg),
    .taken    (branchTaken)
  );

  assign pcUpdate   = pc_write | (pc_write_cond & branchTaken);
  assign imem_req   = (state == F_REQ);
  assign fetch_busy = (state == F_REQ);
  assign opcode     = ir[31:26];

  always_comb begin
    nextPc = pc;
    case (pc_source)
      PC_SRC_ALU:     nextPc = alu_result;
      PC_SRC_ALU_REG: nextPc = aluOutQ;
      PC_SRC_JUMP:    nextPc = {pc[31:28], ir[25:0], 2'b00};
      default:        nextPc = pc;
    endcase
  end

  // The PC can move freely during a fetch; imem_addr was captured at fetch start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= 32'd0;
      aluOutQ <= 32'd0;
    end else begin
      aluOutQ <= alu_result;
      if (pcUpdate)
        pc <= {nextPc[31:2], 2'b00};
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wdCount;

  // Fetch FSM with watchdog: a stalled fetch is replaced by a NoOp and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= F_IDLE;
      imem_addr <= 32'd0;
      ir        <= IR_NOOP;
      wdCount   <= 4'd0;
      fetch_err <= 1'b0;
    end else if (state == F_IDLE) begin
      if (ir_write) begin
        imem_addr <= pc;
        wdCount   <= 4'd0;
        state     <= F_REQ;
      end
    end else begin
      if (imem_ack) begin
        ir    <= imem_rdata;
        state <= F_IDLE;
      end else if (wdCount == WD_LIMIT) begin
        ir        <= IR_NOOP;
        fetch_err <= 1'b1;
        state     <= F_IDLE;
      end else begin
        wdCount <= wdCount + 4'd1;
      end
    end
  end
`else
  // Fetch FSM: acks outside F_REQ and ir_write during F_REQ are both dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= F_IDLE;
      imem_addr <= 32'd0;
      ir        <= IR_NOOP;
    end else if (state == F_IDLE) begin
      if (ir_write) begin
        imem_addr <= pc;
        state     <= F_REQ;
      end
    end else begin
      if (imem_ack) begin
        ir    <= imem_rdata;
        state <= F_IDLE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a branch-type table
// and randomized traffic against a behavioural model (FETCH_TIMEOUT_EN aware).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, ir_write, pc_write_cond, alu_zero_cond, blt_cond;
  logic [1:0]  pc_source;
  logic [31:0] alu_result;
  logic        alu_zero, alu_neg;
  logic        imem_req, imem_ack, fetch_busy;
  logic [31:0] imem_addr, imem_rdata, pc, ir;
  logic [5:0]  opcode;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] mPc, mIr, mAddr, mAluQ;
  logic        mBusy, mErr;
  int          mWait;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .pc_write_cond (pc_write_cond),
    .alu_zero_cond (alu_zero_cond),
    .blt_cond      (blt_cond),
    .pc_source     (pc_source),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_neg       (alu_neg),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .ir            (ir),
    .opcode        (opcode),
`ifdef FETCH_TIMEOUT_EN
    .fetch_err     (fetch_err),
`endif
    .fetch_busy    (fetch_busy)
  );

  typedef struct {
    logic       zc;
    logic       bc;
    logic       zero;
    logic       neg;
    logic       taken;
    string      name;
  } branchVec_t;

  branchVec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic pw, input logic iw, input logic pwc,
                               input logic zc, input logic bc, input logic [1:0] src,
                               input logic [31:0] alu, input logic z, input logic n,
                               input logic ack, input logic [31:0] rdata);
    pc_write = pw; ir_write = iw; pc_write_cond = pwc;
    alu_zero_cond = zc; blt_cond = bc; pc_source = src;
    alu_result = alu; alu_zero = z; alu_neg = n;
    imem_ack = ack; imem_rdata = rdata;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 32'd0, 0, 0, 0, 32'd0);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc"}, pc, mPc);
    checkOutput({tag, ".ir"}, ir, mIr);
    checkOutput({tag, ".opcode"}, {26'd0, opcode}, {26'd0, mIr[31:26]});
    checkOutput({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, mBusy});
    checkOutput({tag, ".fetch_busy"}, {31'd0, fetch_busy}, {31'd0, mBusy});
    checkOutput({tag, ".imem_addr"}, imem_addr, mAddr);
`ifdef FETCH_TIMEOUT_EN
    checkOutput({tag, ".fetch_err"}, {31'd0, fetch_err}, {31'd0, mErr});
`endif
  endtask

  // Advance one clock: model computes the architectural effect of this cycle.
  task automatic tick();
    logic        taken;
    logic [31:0] target;
    if (alu_zero_cond && blt_cond)       taken = alu_zero || alu_neg;
    else if (alu_zero_cond)              taken = alu_zero;
    else if (blt_cond)                   taken = alu_neg;
    else                                 taken = !alu_zero;
    if (pc_source == 2'd0)               target = alu_result;
    else if (pc_source == 2'd1)          target = mAluQ;
    else if (pc_source == 2'd2)          target = {mPc[31:28], mIr[25:0], 2'b00};
    else                                 target = mPc;
    if (!mBusy) begin
      if (ir_write) begin
        mAddr = mPc;
        mBusy = 1'b1;
        mWait = 0;
      end
    end else if (imem_ack) begin
      mIr = imem_rdata;
      mBusy = 1'b0;
    end else begin
`ifdef FETCH_TIMEOUT_EN
      mWait++;
      if (mWait == 15) begin
        mIr = 32'hFC000000;
        mBusy = 1'b0;
        mErr = 1'b1;
      end
`endif
    end
    if (pc_write || (pc_write_cond && taken))
      mPc = target & 32'hFFFF_FFFC;
    mAluQ = alu_result;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    mPc = 0; mIr = 32'hFC000000; mAddr = 0; mAluQ = 0; mBusy = 0; mErr = 0; mWait = 0;
    checkAll("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pcBefore, addrHeld;
    vecs[0] = '{0, 0, 0, 0, 1, "bne_nz"};
    vecs[1] = '{0, 0, 1, 0, 0, "bne_z"};
    vecs[2] = '{1, 0, 1, 0, 1, "beq_z"};
    vecs[3] = '{1, 0, 0, 1, 0, "beq_nz"};
    vecs[4] = '{0, 1, 0, 1, 1, "blt_neg"};
    vecs[5] = '{0, 1, 1, 0, 0, "blt_pos"};
    vecs[6] = '{1, 1, 0, 1, 1, "ble_neg"};
    vecs[7] = '{1, 1, 1, 0, 1, "ble_z"};
    vecs[8] = '{1, 1, 0, 0, 0, "ble_pos"};

    idleInputs();
    @(posedge clk);
    #1;
    doReset();
    checkOutput("reset.opcode_noop", {26'd0, opcode}, 32'h3F);

    // Basic fetch: ir_write, ack one cycle later.
    applyStimulus(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    tick();
    checkAll("fetch.req");
    checkOutput("fetch.addr0", imem_addr, 32'd0);
    checkOutput("fetch.req_high", {31'd0, imem_req}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 1, 32'h04000010);
    tick();
    checkAll("fetch.ack");
    checkOutput("fetch.opcode", {26'd0, opcode}, 32'h01);
    checkOutput("fetch.busy_low", {31'd0, fetch_busy}, 32'd0);

    // Jump target from ir.
    applyStimulus(1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0);
    tick();
    checkOutput("jump.pc", pc, 32'h00000040);
    checkAll("jump");

    // Ack while idle is ignored.
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 1, 32'hDEADBEEF);
    tick();
    checkOutput("idle_ack.ir", ir, 32'h04000010);

    // Branch table: load a target into alu_out_q, then resolve one branch.
    for (int i = 0; i < 9; i++) begin
      logic [31:0] tgt;
      tgt = 32'h100 + 32'(i) * 32'h10;
      applyStimulus(0, 0, 0, 0, 0, 2'b11, tgt, 0, 0, 0, 0);
      tick();
      pcBefore = mPc;
      applyStimulus(0, 0, 1, vecs[i].zc, vecs[i].bc, 2'b01, 32'h0000_0F00,
                    vecs[i].zero, vecs[i].neg, 0, 0);
      tick();
      checkOutput({"branch.", vecs[i].name}, pc, vecs[i].taken ? tgt : pcBefore);
    end

    // PC update during an outstanding fetch leaves imem_addr alone.
    addrHeld = mPc;
    applyStimulus(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 1, 1, 0, 2'b00, 32'h203, 1, 0, 0, 0);
    tick();
    checkOutput("inflight.pc", pc, 32'h200);
    checkOutput("inflight.addr", imem_addr, addrHeld);
    idleInputs();
    tick();
    checkOutput("inflight.addr_hold", imem_addr, addrHeld);
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 1, 32'h2C000001);
    tick();
    checkAll("inflight.ack");
    checkOutput("inflight.ir", ir, 32'h2C000001);

    // Reset mid-fetch, then a late ack.
    applyStimulus(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    tick();
    checkOutput("midrst.req_before", {31'd0, imem_req}, 32'd1);
    idleInputs();
    doReset();
    checkOutput("midrst.req", {31'd0, imem_req}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 1, 32'h12345678);
    tick();
    checkOutput("midrst.ir", ir, 32'hFC000000);
    checkAll("midrst");

`ifdef FETCH_TIMEOUT_EN
    applyStimulus(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    tick();
    idleInputs();
    for (int i = 0; i < 14; i++) tick();
    checkOutput("timeout.still_busy", {31'd0, fetch_busy}, 32'd1);
    tick();
    checkOutput("timeout.err", {31'd0, fetch_err}, 32'd1);
    checkOutput("timeout.opcode", {26'd0, opcode}, 32'h3F);
    checkOutput("timeout.idle", {31'd0, imem_req}, 32'd0);
    checkAll("timeout");
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 3, 1'($urandom), 1'($urandom),
                    2'($urandom), $urandom, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 9) < 4, $urandom);
      tick();
      checkAll("random");
      if (c == 200) begin
        idleInputs();
        doReset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 rst  input  1  Reset, asynchronous, active-high.
REQ-003 pc_write  input  1  Unconditional PC update strobe from the controller.
REQ-004 ir_write  input  1  Fetch start strobe from the controller.
REQ-005 pc_write_cond  input  1  Conditional (branch) PC update strobe.
REQ-006 alu_zero_cond  input  1  Branch type select, bit A.
REQ-007 blt_cond  input  1  Branch type select, bit B.
REQ-008 pc_source  input  2  Next-PC select.
REQ-009 alu_result  input  32  Combinational ALU result.
REQ-010 alu_zero, alu_neg  input  1 each  ALU flags for the current cycle.
REQ-011 imem_req  output  1  Instruction memory request; held until acknowledged.
REQ-012 imem_addr  output  32  Fetch address; stable while imem_req is high.
REQ-013 imem_ack, imem_rdata  input  1/32  Memory acknowledge and read data, sampled together.
REQ-014 pc, ir  output  32 each  Architectural PC and instruction register.
REQ-015 opcode  output  6  Equal to ir[31:26].
REQ-016 fetch_busy  output  1  High whenever a fetch is outstanding.

Function
REQ-017 Fetch FSM states: F_IDLE and F_REQ; ir_write in F_IDLE latches imem_addr<=pc, then moves to F_REQ.
REQ-018 In F_REQ: imem_req=1 and fetch_busy=1; on imem_ack, ir<=imem_rdata and the FSM returns to F_IDLE. Minimum latency from ir_write to new ir is 2 edges.
REQ-019 ir_write received while in F_REQ is ignored; no second request is queued.
REQ-020 The ALU output register alu_out_q<=alu_result every cycle.
REQ-021 Next PC is selected by pc_source: 00 = alu_result, 01 = alu_out_q, 10 = {pc[31:28], ir[25:0], 2'b00}, 11 = pc (hold).
REQ-022 Branch taken, by {alu_zero_cond, blt_cond}: 00 = ~alu_zero (BNE); 10 = alu_zero (BEQ); 01 = alu_neg (BLT); 11 = alu_zero|alu_neg (BLE).
REQ-023 pc updates when pc_write=1, or when pc_write_cond=1 and the branch is taken; if both fire in one cycle, a single update occurs.
REQ-024 pc[1:0] is forced to 00 on every update, keeping the PC word aligned.
REQ-025 A PC update during F_REQ does not alter imem_addr of the in-flight fetch.
REQ-026 imem_ack while in F_IDLE is ignored and ir is unchanged.

Reset
REQ-027 rst=1 immediately forces: F_IDLE, imem_req=0, fetch_busy=0, pc=0, imem_addr=0, alu_out_q=0, ir=32'hFC000000 (opcode 6'b111111, NoOp).
REQ-028 Reset asserted mid-fetch abandons the fetch; a late imem_ack after reset release is ignored per REQ-026.

Configuration
REQ-029 With FETCH_TIMEOUT_EN defined, a 4-bit watchdog counts F_REQ cycles. At 15 cycles without imem_ack: ir<=32'hFC000000, the FSM returns to F_IDLE, and an extra output fetch_err (1 bit, sticky until rst) is set.
REQ-030 Without FETCH_TIMEOUT_EN: no counter and no fetch_err port; F_REQ waits indefinitely.

Structure
REQ-031 The shared package holds the opcode constants (NoOp, J, BEQ, BNE, BLT, BLE, LI, LUI, LWI, SWI), the pc_source encodings, the NoOp IR reset constant, and the fetch FSM state typedef.
REQ-032 Sub-module branch_cond: combinational taken-decision per REQ-022, instantiated once.

Verification
REQ-033 Reset, then ir_write with pc=0 and imem_ack one cycle later carrying 32'h04000010 -> imem_addr=0, opcode=6'b000001, fetch_busy low after the ack edge.
REQ-034 pc_source=10, ir=32'h04000010, pc_write=1 -> pc=32'h00000040.
REQ-035 pc_write_cond=1, alu_zero_cond=1, blt_cond=1, alu_zero=0, alu_neg=1, alu_out_q=32'h100 (pc_source=01) -> pc=32'h100; repeat with alu_neg=0 -> pc unchanged.
REQ-036 pc_write=1 with alu_result=32'h203 during F_REQ -> pc=32'h200 and imem_addr unchanged until ack.
REQ-037 rst asserted while imem_req=1, then ack after release -> imem_req=0 immediately, ir=32'hFC000000.
REQ-038 FETCH_TIMEOUT_EN defined, no ack for 15 cycles -> fetch_err=1, opcode=6'b111111, F_IDLE.
